// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the 16-bit CISC-V multi-cycle controller.
package cpu_pkg;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1110;
  localparam logic [3:0] OP_JMP = 4'b1111;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [1:0] PC_INC = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  typedef struct packed {
    logic       is_alu;
    logic       is_lw;
    logic       is_sw;
    logic       is_bne;
    logic       is_jmp;
    logic       legal;
    logic [2:0] alu_op;
  } dec_t;
endpackage

// File: rtl/mc_decode.sv
// mc_decode: opcode classification and ALU function lookup.
module mc_decode
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
);
  always_comb begin
    dec = '0;
    case (op)
      OP_ADD: begin dec.is_alu = 1'b1; dec.alu_op = ALU_ADD; end
      OP_SUB: begin dec.is_alu = 1'b1; dec.alu_op = ALU_SUB; end
      OP_AND: begin dec.is_alu = 1'b1; dec.alu_op = ALU_AND; end
      OP_OR:  begin dec.is_alu = 1'b1; dec.alu_op = ALU_OR; end
      OP_SLT: begin dec.is_alu = 1'b1; dec.alu_op = ALU_SLT; end
      OP_LW:  begin dec.is_lw = 1'b1; dec.alu_op = ALU_ADD; end
      OP_SW:  begin dec.is_sw = 1'b1; dec.alu_op = ALU_ADD; end
      OP_BNE: begin dec.is_bne = 1'b1; dec.alu_op = ALU_SUB; end
      OP_JMP: begin dec.is_jmp = 1'b1; dec.alu_op = ALU_ADD; end
      default: dec = '0;
    endcase
    dec.legal = dec.is_alu | dec.is_lw | dec.is_sw | dec.is_bne | dec.is_jmp;
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with retired-instruction counter.
module multicycle_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic        alu_zero,
  input  logic        i_ready,
  input  logic        d_ready,
  output logic        i_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [2:0]  alu_op,
  output logic        alu_src,
  output logic        reg_dest,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic        illegal,
  output logic [15:0] instr_count
);
  logic [2:0] state, nxt;
  logic [3:0] op_q, dec_op;
  logic       fetch, decode, exec, mem, wb, retire;
  dec_t       dec;
  assign fetch  = state == S_FETCH;
  assign decode = state == S_DECODE;
  assign exec   = state == S_EXEC;
  assign mem    = state == S_MEM;
  assign wb     = state == S_WB;
  // op_q is only loaded at the end of DECODE, so legality there comes straight from the IR
  assign dec_op = decode ? opcode : op_q;
  mc_decode u_dec (.op(dec_op), .dec(dec));
  assign nxt = fetch  ? (i_ready ? S_DECODE : S_FETCH)
             : decode ? (dec.legal ? S_EXEC : S_FETCH)
             : exec   ? (dec.is_alu ? S_WB : (dec.is_lw | dec.is_sw) ? S_MEM : S_FETCH)
             : mem    ? (!d_ready ? S_MEM : dec.is_lw ? S_WB : S_FETCH)
             : S_FETCH;
  assign retire = wb | (exec & (dec.is_bne | dec.is_jmp)) | (mem & d_ready & dec.is_sw);
  assign i_req      = fetch;
  assign ir_write   = !rst & fetch & i_ready;
  assign pc_write   = !rst & ((fetch & i_ready) | (exec & (dec.is_jmp | (dec.is_bne & !alu_zero))));
  assign pc_src     = (exec & dec.is_bne) ? PC_BR : (exec & dec.is_jmp) ? PC_JMP : PC_INC;
  assign alu_op     = exec ? dec.alu_op : ALU_ADD;
  assign alu_src    = exec & (dec.is_lw | dec.is_sw);
  assign reg_write  = wb;
  assign reg_dest   = wb & dec.is_lw;
  assign mem_to_reg = wb & dec.is_lw;
  assign mem_read   = mem & dec.is_lw;
  assign mem_write  = mem & dec.is_sw;
  assign illegal    = decode & !dec.legal;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      op_q        <= '0;
      instr_count <= '0;
    end else begin
      state <= nxt;
      if (decode) op_q <= opcode;
      if (retire) instr_count <= instr_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: per-cycle scoreboard against a per-instruction reference model.
module tb_multicycle_ctrl;
  logic        clk = 0, rst = 1;
  logic [3:0]  opcode = '0;
  logic        alu_zero = 0, i_ready = 0, d_ready = 0;
  logic        i_req, ir_write, pc_write, alu_src, reg_dest, reg_write;
  logic        mem_to_reg, mem_read, mem_write, illegal;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op;
  logic [15:0] instr_count;
  typedef struct packed {
    logic       i_req, ir_write, pc_write;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       alu_src, reg_dest, reg_write, mem_to_reg, mem_read, mem_write, illegal;
    logic [15:0] cnt;
  } out_t;
  out_t  exp_q[$];
  string name_q[$];
  int    total = 0, passed = 0;
  logic [15:0] cnt_m = '0;
  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero),
    .i_ready(i_ready), .d_ready(d_ready), .i_req(i_req), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_op(alu_op), .alu_src(alu_src),
    .reg_dest(reg_dest), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .mem_read(mem_read), .mem_write(mem_write), .illegal(illegal),
    .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction
  // 0 illegal, 1 ALU, 2 lw, 3 sw, 4 bne, 5 jmp
  function automatic int cls(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111: return 1;
      4'b1000: return 2;
      4'b1010: return 3;
      4'b1110: return 4;
      4'b1111: return 5;
      default: return 0;
    endcase
  endfunction
  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      4'b0110: return 3'b001;
      4'b0000: return 3'b010;
      4'b0001: return 3'b100;
      4'b0111: return 3'b011;
      default: return 3'b000;
    endcase
  endfunction
  function automatic out_t idle();
    out_t o = '0;
    o.cnt = cnt_m;
    return o;
  endfunction
  task automatic cyc(input logic ir, dr, az, r, input logic [3:0] opc, input out_t e,
                     input string nm, input bit pre);
    @(posedge clk);
    if (pre) begin
      force dut.instr_count = 16'hFFFF;
      #1 release dut.instr_count;
    end else #1;
    rst = r; i_ready = ir; d_ready = dr; alu_zero = az; opcode = opc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask
  task automatic instr(input logic [3:0] op, input int fw, mw, input logic az, input bit pre, kill);
    out_t e;
    int   c = cls(op);
    if (pre) cnt_m = 16'hFFFF;
    for (int k = 0; k < fw; k++) begin
      e = idle(); e.i_req = 1;
      cyc(0, rb(), rb(), 0, rop(), e, "fetch_wait", pre && k == 0);
    end
    e = idle(); e.i_req = 1; e.ir_write = 1; e.pc_write = 1;
    cyc(1, rb(), rb(), 0, rop(), e, "fetch", 0);
    e = idle(); e.illegal = (c == 0);
    cyc(rb(), rb(), rb(), 0, op, e, "decode", 0);
    if (c == 0) return;
    e = idle();
    e.alu_op = (c == 1) ? alu_code(op) : (c == 4) ? 3'b001 : 3'b000;
    e.alu_src = (c == 2 || c == 3);
    e.pc_src = (c == 4) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00;
    e.pc_write = (c == 5) || (c == 4 && !az);
    cyc(rb(), rb(), az, 0, rop(), e, "exec", 0);
    if (c >= 4) begin cnt_m++; return; end
    if (c == 2 || c == 3) begin
      e = idle(); e.mem_read = (c == 2); e.mem_write = (c == 3);
      if (kill) begin
        cyc(rb(), 0, rb(), 0, rop(), e, "mem", 0);
        cnt_m = '0;
        e = idle(); e.i_req = 1;
        cyc(1, 1, rb(), 1, rop(), e, "rst_mid_sw", 0);
        return;
      end
      for (int k = 0; k < mw; k++) cyc(rb(), 0, rb(), 0, rop(), e, "mem_wait", 0);
      cyc(rb(), 1, rb(), 0, rop(), e, "mem", 0);
      if (c == 3) begin cnt_m++; return; end
    end
    e = idle(); e.reg_write = 1; e.reg_dest = (c == 2); e.mem_to_reg = (c == 2);
    cyc(rb(), rb(), rb(), 0, rop(), e, "wb", 0);
    cnt_m++;
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t  e, a;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a = {i_req, ir_write, pc_write, pc_src, alu_op, alu_src, reg_dest, reg_write,
           mem_to_reg, mem_read, mem_write, illegal, instr_count};
      total++;
      if (a === e) passed++;
      else $display("FAIL %s @%0t: got %h expected %h", nm, $time, a, e);
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    out_t e;
    e = idle(); e.i_req = 1;
    cyc(1, 1, 0, 1, 4'h0, e, "reset", 0);
    cyc(1, 1, 0, 1, 4'h0, e, "reset", 0);
    instr(4'b0010, 0, 0, 0, 0, 0);
    instr(4'b1000, 0, 3, 0, 0, 0);
    instr(4'b1110, 0, 0, 0, 0, 0);
    instr(4'b1110, 1, 0, 1, 0, 0);
    instr(4'b0011, 0, 0, 0, 0, 0);
    instr(4'b0110, 2, 0, 0, 0, 0);
    instr(4'b1010, 0, 0, 0, 0, 1);
    instr(4'b1010, 1, 2, 0, 0, 0);
    instr(4'b1111, 2, 0, 0, 1, 0);
    instr(4'b1111, 0, 0, 0, 0, 0);
    for (int n = 0; n < 300; n++)
      instr(rop(), $urandom_range(0, 2), $urandom_range(0, 3), rb(), 0, n % 97 == 50);
    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the 16-bit CISC-V core. It replaces single-cycle decoding with a state machine that drives fetch, decode, execute, memory and write-back over several cycles. It generates every datapath select and enable, and handshakes with instruction and data memory through req/ready pairs. It sits between the instruction register and the shared datapath (PC, register file, ALU, data memory) and also keeps a retired-instruction counter.

## Interface
- No parameters. Width and encodings are fixed by the shared package.
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  4  IR[15:12]; valid from the cycle after ir_write
- alu_zero  in  1  ALU zero flag, valid in EXEC
- i_ready  in  1  instruction memory has the word on the bus
- d_ready  in  1  data memory completed the access
- i_req  out  1  instruction fetch request
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_src  out  2  PC source: 00 = pc+2, 01 = branch target, 10 = jump target
- alu_op  out  3  ALU function
- alu_src  out  1  ALU B operand: 0 = register, 1 = sign-extended immediate
- reg_dest  out  1  destination field select (0 = rd, 1 = rt)
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  write-back source is memory
- mem_read  out  1  data read request
- mem_write  out  1  data write request
- illegal  out  1  one-cycle pulse on an undefined opcode
- instr_count  out  16  retired instructions, wraps at 16'hFFFF -> 0

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB. Encoding lives in the package.
- **FETCH**
  - i_req=1.
  - On i_ready: ir_write=1, pc_write=1, pc_src=00, go to DECODE. Otherwise hold.
- **DECODE**
  - Register opcode into op_q. All later states use op_q only.
  - Undefined opcode: illegal=1 this cycle, go to FETCH, no count.
  - Otherwise go to EXEC.
- **EXEC**
  - ALU ops (add 0010, sub 0110, and 0000, or 0001, slt 0111): alu_src=0, then WB.
  - alu_op encodings: add 000, sub 001, and 010, or 100, slt 011.
  - lw 1000 / sw 1010: alu_op=000, alu_src=1, then MEM.
  - bne 1110: alu_op=001, pc_src=01, pc_write=~alu_zero. Retire, then FETCH.
  - jmp 1111: pc_src=10, pc_write=1. Retire, then FETCH.
- **MEM**
  - lw: mem_read=1 until d_ready, then WB.
  - sw: mem_write=1 until d_ready. On d_ready retire, then FETCH.
  - mem_read and mem_write are never both high.
- **WB**
  - reg_write=1.
  - ALU ops: reg_dest=0, mem_to_reg=0.
  - lw: reg_dest=1, mem_to_reg=1.
  - Retire, then FETCH.
- **Outputs**
  - All outputs not listed for a state are 0 in that state.
  - pc_write and ir_write in FETCH/EXEC are the only outputs that depend on inputs (Mealy); all others are Moore.
- **Retire:** instr_count += 1 on the final cycle of each legal instruction.

## Timing
- **Reset (asynchronous)**
  - state=FETCH, op_q=0, instr_count=0.
  - Outputs during reset: i_req=1, all others 0.
  - Reset mid-instruction abandons it with no retire and no partial write. The next fetch starts the cycle after deassertion.
- **Minimum latency** (i_ready/d_ready high on first request):
  - ALU ops: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - bne/jmp: 3 cycles.
  - Illegal: 2 cycles.
- **Wait states:** each cycle i_ready or d_ready is low adds exactly one cycle. Request outputs stay asserted and all other outputs stay stable.
- **Ready outside a request:** i_ready or d_ready asserted while the matching request is low is ignored.
- **Counter wrap:** instr_count wraps with no flag.
- **Back-to-back instructions:** FETCH of the next instruction is the cycle after the retiring cycle. There are no bubbles beyond the state sequence.

## Structure
- Package cpu_pkg holds:
  - opcode constants (OP_ADD … OP_JMP);
  - ALU op codes (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_SLT=011, ALU_OR=100);
  - PC source codes;
  - state encoding.
- One combinational sub-module, mc_decode: op_q -> {is_alu, is_lw, is_sw, is_bne, is_jmp, legal, alu_op}.
- The FSM, output logic and counter stay in multicycle_ctrl.

## Test plan
- Reset, then add (0010) with ready always high: expect FETCH -> DECODE -> EXEC -> WB. reg_write=1 in cycle 4 only with alu_op=000, and instr_count=1.
- lw (1000) with d_ready held low for 3 cycles: mem_read stays high for 4 cycles. Then WB has reg_dest=1, mem_to_reg=1. Total 8 cycles.
- bne (1110) with alu_zero=0 gives pc_write=1, pc_src=01 in EXEC. Repeat with alu_zero=1: pc_write=0. Both retire in 3 cycles.
- Opcode 0011: illegal pulses one cycle in DECODE, next state FETCH, and reg_write, mem_write and instr_count are unchanged.
- Assert rst during MEM of a sw: mem_write drops immediately and instr_count=0. After release, i_req=1 and the state is FETCH.
- Preload 65535 retires via a jmp loop; the next retire gives instr_count=0.
